julia_render_ctrl: RTL

//  Sequences the Julia pixel-iteration engine that fills the fractal frame buffer.

---
 rtl/julia_pkg.sv | 36 +++
 rtl/julia_render_ctrl_btn_debounce.sv | 46 ++++
 rtl/julia_render_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia render controller:
// Q4.12 coordinate type, FSM states and the c-parameter preset table.
package julia_pkg;

  localparam int unsigned COORD_W_DEF = 16;
  localparam int unsigned ADDR_W      = 16;

  typedef logic signed [15:0] q4_12_t;

  localparam q4_12_t STEP0_DEF = 16'sh0033;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    q4_12_t re;
    q4_12_t im;
  } cplx_t;

  // Presets rounded to nearest Q4.12 value.
  function automatic cplx_t c_table(input logic [1:0] idx);
    cplx_t c;
    case (idx)
      2'd0:    begin c.re = 16'shF333; c.im = 16'sh027F; end // (-0.8,     0.156)
      2'd1:    begin c.re = 16'sh048F; c.im = 16'sh0029; end // ( 0.285,   0.01)
      2'd2:    begin c.re = 16'shF99A; c.im = 16'sh099A; end // (-0.4,     0.6)
      default: begin c.re = 16'shF4C6; c.im = 16'shF9DA; end // (-0.70176,-0.3842)
    endcase
    return c;
  endfunction

endpackage

// File: rtl/julia_render_ctrl_btn_debounce.sv
// Single-button debouncer: two-flop synchroniser, then the clean level follows
// the synchronised input once it has stayed different for DEB_CYC cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned     CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_btn};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/julia_render_ctrl.sv
// Julia render sequencer: buttons -> pending view parameters; on a v_sync rising
// edge with pending changes, commits them and issues one job per buffer pixel.
module julia_render_ctrl
  import julia_pkg::*;
#(
  parameter int unsigned         FB_W     = 320,
  parameter int unsigned         FB_H     = 180,
  parameter int unsigned         COORD_W  = COORD_W_DEF,
  parameter logic [COORD_W-1:0]  STEP0    = COORD_W'(STEP0_DEF),
  parameter int unsigned         ZOOM_MAX = 7,
  parameter int unsigned         DEB_CYC  = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         i_btn,
  input  logic               i_v_sync,
  output logic               o_job_valid,
  input  logic               i_job_ready,
  output logic [COORD_W-1:0] o_job_re,
  output logic [COORD_W-1:0] o_job_im,
  output logic [ADDR_W-1:0]  o_job_addr,
  input  logic               i_engine_idle,
  output logic [COORD_W-1:0] o_c_re,
  output logic [COORD_W-1:0] o_c_im,
  output logic [2:0]         o_zoom,
  output logic               o_busy,
  output logic               o_frame_done
);

  localparam int unsigned          XW     = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int unsigned          YW     = (FB_H > 1) ? $clog2(FB_H) : 1;
  localparam logic [XW-1:0]        X_LAST = XW'(FB_W - 1);
  localparam logic [YW-1:0]        Y_LAST = YW'(FB_H - 1);
  localparam logic [2:0]           ZMAX   = 3'(ZOOM_MAX);
  localparam logic [COORD_W-1:0]   HALF_W = COORD_W'(FB_W / 2);
  localparam logic [COORD_W-1:0]   HALF_H = COORD_W'(FB_H / 2);

  logic [2:0] btn_lvl;

  for (genvar g = 0; g < 3; g++) begin : g_deb
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn[g]),
      .o_level (btn_lvl[g])
    );
  end

  state_t               state_q, state_d;
  logic [2:0]           btn_prev_q;
  logic                 vs_prev_q;
  logic [1:0]           pend_preset_q, pend_preset_d;
  logic [2:0]           pend_zoom_q, pend_zoom_d;
  logic                 dirty_q, dirty_d;
  logic [COORD_W-1:0]   c_re_q, c_re_d, c_im_q, c_im_d;
  logic [2:0]           zoom_q, zoom_d;
  logic [COORD_W-1:0]   step_q, step_d, re0_q, re0_d;
  logic [COORD_W-1:0]   re_q, re_d, im_q, im_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic [2:0]           btn_ev;
  logic                 vs_edge, accept;
  logic [COORD_W-1:0]   step_init;
  cplx_t                c_sel;

  always_comb begin
    btn_ev    = btn_lvl & ~btn_prev_q;
    vs_edge   = i_v_sync & ~vs_prev_q;
    accept    = valid_q & i_job_ready;
    step_init = STEP0 >> pend_zoom_q;
    c_sel     = c_table(pend_preset_q);

    state_d       = state_q;
    pend_preset_d = pend_preset_q;
    pend_zoom_d   = pend_zoom_q;
    dirty_d       = dirty_q;
    c_re_d        = c_re_q;
    c_im_d        = c_im_q;
    zoom_d        = zoom_q;
    step_d        = step_q;
    re0_d         = re0_q;
    re_d          = re_q;
    im_d          = im_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    if (btn_ev[0]) pend_preset_d = pend_preset_q + 2'd1;
    // Simultaneous zoom-in and zoom-out cancel out.
    if (btn_ev[1] && !btn_ev[2] && pend_zoom_q != ZMAX) pend_zoom_d = pend_zoom_q + 3'd1;
    if (btn_ev[2] && !btn_ev[1] && pend_zoom_q != 3'd0) pend_zoom_d = pend_zoom_q - 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (vs_edge && dirty_q) state_d = ST_INIT;
      end
      ST_INIT: begin
        c_re_d  = COORD_W'(c_sel.re);
        c_im_d  = COORD_W'(c_sel.im);
        zoom_d  = pend_zoom_q;
        step_d  = step_init;
        re0_d   = '0 - COORD_W'(step_init * HALF_W);
        re_d    = '0 - COORD_W'(step_init * HALF_W);
        im_d    = COORD_W'(step_init * HALF_H);
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        dirty_d = 1'b0;
        busy_d  = 1'b1;
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d  = '0;
            re_d = re0_q;
            if (y_q == Y_LAST) begin
              valid_d = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              y_d  = y_q + YW'(1);
              im_d = im_q - step_q;
            end
          end else begin
            x_d  = x_q + XW'(1);
            re_d = re_q + step_q;
          end
        end
      end
      ST_DRAIN: begin
        if (i_engine_idle) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A press during INIT still counts as a change for the next frame.
    if (|btn_ev) dirty_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      btn_prev_q    <= '0;
      vs_prev_q     <= 1'b0;
      pend_preset_q <= '0;
      pend_zoom_q   <= '0;
      dirty_q       <= 1'b1;
      c_re_q        <= '0;
      c_im_q        <= '0;
      zoom_q        <= '0;
      step_q        <= '0;
      re0_q         <= '0;
      re_q          <= '0;
      im_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_prev_q    <= btn_lvl;
      vs_prev_q     <= i_v_sync;
      pend_preset_q <= pend_preset_d;
      pend_zoom_q   <= pend_zoom_d;
      dirty_q       <= dirty_d;
      c_re_q        <= c_re_d;
      c_im_q        <= c_im_d;
      zoom_q        <= zoom_d;
      step_q        <= step_d;
      re0_q         <= re0_d;
      re_q          <= re_d;
      im_q          <= im_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign o_job_valid  = valid_q;
  assign o_job_re     = re_q;
  assign o_job_im     = im_q;
  assign o_job_addr   = addr_q;
  assign o_c_re       = c_re_q;
  assign o_c_im       = c_im_q;
  assign o_zoom       = zoom_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule
